// File: rtl/host_io_pkg.sv
// rtl/host_io_pkg.sv - register map constants for the host-I/O MMIO block
package host_io_pkg;

    localparam int SEL_BIT = 29;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_COUNT  = 2'd2;

    localparam int TX_READY_BIT = 16;
    localparam int RX_VALID_BIT = 17;
    localparam int OVF_BIT      = 24;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with first-word-fall-through head
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/host_io_mmio.sv
// rtl/host_io_mmio.sv - yarvi MMIO bridge to the HostIoComm byte FIFOs
module host_io_mmio
    import host_io_pkg::*;
#(
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int RX_DEPTH_LOG2 = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] address,
    input  logic        writeenable,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteena,
    input  logic        readenable,
    output logic [31:0] readdata,
    input  logic [7:0]  host_rx_data,
    input  logic        host_rx_empty,
    output logic        host_rx_rmv,
    output logic [7:0]  host_tx_data,
    output logic        host_tx_add,
    input  logic        host_tx_full
);

    logic                   sel;
    logic [1:0]             reg_idx;
    logic                   data_store;
    logic                   tx_push;
    logic                   ovf_set;
    logic                   ovf_clr;
    logic                   ovf;
    logic                   rx_pop;
    logic                   tx_drain;
    logic                   rx_fill;
    logic [31:0]            read_word;

    logic [7:0]             tx_head;
    logic                   tx_full;
    logic                   tx_empty;
    logic [TX_DEPTH_LOG2:0] tx_count;
    logic [7:0]             rx_head;
    logic                   rx_full;
    logic                   rx_empty;
    logic [RX_DEPTH_LOG2:0] rx_count;

    logic                   unused_bits;

    assign unused_bits = ^{address[28:2], writedata[31:25], writedata[23:8], byteena[3:1]};

    assign sel        = address[SEL_BIT];
    assign reg_idx    = address[1:0];
    assign data_store = sel && writeenable && (reg_idx == REG_DATA) && byteena[0];

    // Full is judged on the pre-edge count, so a drain in the same cycle never rescues a store.
    assign tx_push  = data_store && !tx_full;
    assign ovf_set  = data_store && tx_full;
    assign ovf_clr  = sel && writeenable && (reg_idx == REG_STATUS) && writedata[OVF_BIT];
    assign rx_pop   = sel && readenable && (reg_idx == REG_DATA) && byteena[0] && !rx_empty;

    // Registered strobes gate their own re-issue, giving HostIoComm a settle cycle after each pulse.
    assign tx_drain = !tx_empty && !host_tx_full && !host_tx_add;
    assign rx_fill  = !host_rx_empty && !rx_full && !host_rx_rmv;

    always_comb begin
        read_word = '0;
        if (sel) begin
            case (reg_idx)
                REG_DATA: begin
                    if (!rx_empty) begin
                        read_word[RX_VALID_BIT] = 1'b1;
                        read_word[TX_READY_BIT] = 1'b1;
                        read_word[7:0]          = rx_head;
                    end
                end
                REG_STATUS: begin
                    read_word[TX_READY_BIT] = !tx_full;
                    read_word[RX_VALID_BIT] = !rx_empty;
                    read_word[OVF_BIT]      = ovf;
                end
                REG_COUNT: begin
                    read_word[23:16] = 8'(rx_count);
                    read_word[7:0]   = 8'(tx_count);
                end
                default: read_word = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            readdata     <= '0;
            ovf          <= 1'b0;
            host_tx_add  <= 1'b0;
            host_tx_data <= '0;
            host_rx_rmv  <= 1'b0;
        end else begin
            if (readenable) begin
                readdata <= read_word;
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            host_tx_add <= tx_drain;
            if (tx_drain) begin
                host_tx_data <= tx_head;
            end
            host_rx_rmv <= rx_fill;
        end
    end

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (TX_DEPTH_LOG2)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push),
        .push_data (writedata[7:0]),
        .pop       (tx_drain),
        .head      (tx_head),
        .full      (tx_full),
        .empty     (tx_empty),
        .count     (tx_count)
    );

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (RX_DEPTH_LOG2)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_fill),
        .push_data (host_rx_data),
        .pop       (rx_pop),
        .head      (rx_head),
        .full      (rx_full),
        .empty     (rx_empty),
        .count     (rx_count)
    );

endmodule
